// File: rtl/ibex_mem_responder.sv
// ibex_mem_responder: target end of the Ibex req/gnt/rvalid bus with a byte-enabled word memory.
// Grants after GntDelay cycles of held request; rvalid_o follows the accept edge by RespLatency cycles.
// No response back-pressure; grant is withheld while MaxOutstanding responses are in flight.
// Optional feature macro IBEX_MEM_RESP_ERR_EN: out-of-range words answer err_o=1 instead of aliasing.
module ibex_mem_responder #(
  parameter int unsigned Depth          = 32,
  parameter int unsigned GntDelay       = 0,
  parameter int unsigned RespLatency    = 1,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int unsigned   AW        = $clog2(Depth);
  localparam int unsigned   CW        = $clog2(MaxOutstanding + 1);
  localparam int unsigned   LAST      = RespLatency - 1;
  localparam logic [3:0]    GNT_DELAY = 4'(GntDelay);
  localparam logic [CW-1:0] MAX_OUT   = CW'(MaxOutstanding);

  logic [3:0]    wait_q;
  logic [CW-1:0] outstanding_q;
  logic [31:0]   mem_q      [Depth];
  logic          pipe_vld_q [RespLatency];
  logic [31:0]   pipe_dat_q [RespLatency];
  logic          pipe_err_q [RespLatency];

  logic          accept;
  logic          retire;
  logic          oor;
  logic          delay_ok;
  logic [AW-1:0] idx;
  logic [31:0]   rd_word;
  logic          unused_addr;

  // Bits [1:0] are ignored; upper bits are only consulted by the range check.
  assign unused_addr = ^addr_i;
  assign idx         = addr_i[AW+1:2];

`ifdef IBEX_MEM_RESP_ERR_EN
  assign oor = ({1'b0, addr_i[31:2]} >= 31'(Depth));
`else
  assign oor = 1'b0;
`endif

  // wait_q + 1 > GntDelay is wait_q >= GntDelay without a trivially-true compare at GntDelay = 0.
  assign delay_ok = (({1'b0, wait_q} + 5'd1) > {1'b0, GNT_DELAY});
  assign gnt_o    = req_i && !rst_i && delay_ok && (outstanding_q < MAX_OUT);
  assign accept   = gnt_o;
  assign retire   = pipe_vld_q[LAST];

  // Writes and out-of-range accesses answer with zero data.
  assign rd_word  = (we_i || oor) ? 32'd0 : mem_q[idx];

  assign rvalid_o = pipe_vld_q[LAST];
  assign rdata_o  = pipe_dat_q[LAST];
  assign err_o    = pipe_err_q[LAST];

  // Word storage: byte-lane writes at the accept edge; contents deliberately survive reset.
  always_ff @(posedge clk_i) begin
    if (accept && we_i && !oor) begin
      for (int k = 0; k < 4; k++) begin
        if (be_i[k]) begin
          mem_q[idx][8*k +: 8] <= wdata_i[8*k +: 8];
        end
      end
    end
  end

  // Grant-delay counter, in-flight count and the fixed-length response shift pipeline.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wait_q        <= '0;
      outstanding_q <= '0;
      for (int i = 0; i < int'(RespLatency); i++) begin
        pipe_vld_q[i] <= 1'b0;
        pipe_dat_q[i] <= '0;
        pipe_err_q[i] <= 1'b0;
      end
    end else begin
      if (!req_i || gnt_o) begin
        wait_q <= '0;
      end else if (wait_q != 4'hF) begin
        wait_q <= wait_q + 4'd1;
      end

      case ({accept, retire})
        2'b10:   outstanding_q <= outstanding_q + CW'(1);
        2'b01:   outstanding_q <= outstanding_q - CW'(1);
        default: outstanding_q <= outstanding_q;
      endcase

      // Empty slots carry zero data so rdata_o/err_o idle at 0.
      pipe_vld_q[0] <= accept;
      pipe_dat_q[0] <= accept ? rd_word : 32'd0;
      pipe_err_q[0] <= accept && oor;
      for (int i = 1; i < int'(RespLatency); i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
        pipe_dat_q[i] <= pipe_dat_q[i-1];
        pipe_err_q[i] <= pipe_err_q[i-1];
      end
    end
  end

endmodule
